// File: rtl/chip_shift_writer.sv
// Serial writer for the speckle sensor chip: turns row/column bit writes and
// key-latch requests into timed sclk/sdata/latch pulses with a ready pulse.
module chip_shift_writer #(
  parameter int CLK_DIV   = 4,
  parameter int KEY_PULSE = 8,
  parameter int NB_CNT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_row_write,
  input  logic              i_row_data,
  input  logic              i_col_write,
  input  logic              i_col_data,
  input  logic              i_key_write,
  input  logic              i_clear_cnt,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_row_sdata,
  output logic              o_row_sclk,
  output logic              o_col_sdata,
  output logic              o_col_sclk,
  output logic              o_key_latch,
  output logic [NB_CNT-1:0] o_row_count,
  output logic [NB_CNT-1:0] o_col_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_HOLD,
    S_KEY,
    S_DONE,
    S_RELEASE
  } state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] KEY_LOAD = 8'(KEY_PULSE - 1);
  localparam logic [NB_CNT-1:0] CNT_ONE = {{(NB_CNT-1){1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic [7:0] phase_q, phase_d;
  logic row_req_q, row_req_d, col_req_q, col_req_d, key_req_q, key_req_d;
  logic row_dat_q, row_dat_d, col_dat_q, col_dat_d;
  logic ready_q, ready_d, busy_q, busy_d, key_latch_q, key_latch_d;
  logic row_sdata_q, row_sdata_d, row_sclk_q, row_sclk_d;
  logic col_sdata_q, col_sdata_d, col_sclk_q, col_sclk_d;
  logic [NB_CNT-1:0] row_cnt_q, row_cnt_d, col_cnt_q, col_cnt_d;

  always_comb begin
    state_d   = state_q;
    phase_d   = (phase_q != 8'd0) ? phase_q - 8'd1 : phase_q;
    row_req_d = row_req_q;
    col_req_d = col_req_q;
    key_req_d = key_req_q;
    row_dat_d = row_dat_q;
    col_dat_d = col_dat_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_row_write || i_col_write || i_key_write) begin
          row_req_d = i_row_write;
          col_req_d = i_col_write;
          key_req_d = i_key_write;
          row_dat_d = i_row_data;
          col_dat_d = i_col_data;
          if (i_row_write || i_col_write) begin
            state_d = S_SETUP;
            phase_d = DIV_LOAD;
          end else begin
            state_d = S_KEY;
            phase_d = KEY_LOAD;
          end
        end
      end
      S_SETUP: begin
        if (phase_q == 8'd0) begin
          state_d = S_HIGH;
          phase_d = DIV_LOAD;
        end
      end
      S_HIGH: begin
        if (phase_q == 8'd0) begin
          state_d = S_HOLD;
          phase_d = DIV_LOAD;
        end
      end
      S_HOLD: begin
        if (phase_q == 8'd0) begin
          if (key_req_q) begin
            state_d = S_KEY;
            phase_d = KEY_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_KEY: begin
        if (phase_q == 8'd0) state_d = S_DONE;
      end
      S_DONE:    state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // Pins are registered from the next state so they change on state entry.
    ready_d     = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    key_latch_d = (state_d == S_KEY);
    row_sclk_d  = row_req_d && (state_d == S_HIGH);
    col_sclk_d  = col_req_d && (state_d == S_HIGH);
    row_sdata_d = (row_req_d && state_d == S_SETUP) ? row_dat_d : row_sdata_q;
    col_sdata_d = (col_req_d && state_d == S_SETUP) ? col_dat_d : col_sdata_q;

    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    if (i_clear_cnt) begin
      row_cnt_d = '0;
      col_cnt_d = '0;
    end else if (state_q == S_DONE) begin
      if (row_req_q) row_cnt_d = row_cnt_q + CNT_ONE;
      if (col_req_q) col_cnt_d = col_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= 8'd0;
      row_req_q   <= 1'b0;
      col_req_q   <= 1'b0;
      key_req_q   <= 1'b0;
      row_dat_q   <= 1'b0;
      col_dat_q   <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      key_latch_q <= 1'b0;
      row_sdata_q <= 1'b0;
      row_sclk_q  <= 1'b0;
      col_sdata_q <= 1'b0;
      col_sclk_q  <= 1'b0;
      row_cnt_q   <= '0;
      col_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      row_req_q   <= row_req_d;
      col_req_q   <= col_req_d;
      key_req_q   <= key_req_d;
      row_dat_q   <= row_dat_d;
      col_dat_q   <= col_dat_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      key_latch_q <= key_latch_d;
      row_sdata_q <= row_sdata_d;
      row_sclk_q  <= row_sclk_d;
      col_sdata_q <= col_sdata_d;
      col_sclk_q  <= col_sclk_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_busy      = busy_q;
  assign o_key_latch = key_latch_q;
  assign o_row_sdata = row_sdata_q;
  assign o_row_sclk  = row_sclk_q;
  assign o_col_sdata = col_sdata_q;
  assign o_col_sclk  = col_sclk_q;
  assign o_row_count = row_cnt_q;
  assign o_col_count = col_cnt_q;

endmodule
